// File: rtl/gun_sampler.sv
// ============================================================================
// Module      : gun_sampler
// Description : Light-gun header sampler: synchronizes the raw GPIO, captures
//               clamped cursor coordinates on each strobe rise, debounces the
//               trigger and issues rate-limited single-cycle shot pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gun_sampler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 2500000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [35:0] GPIO,
    input  logic        fire_enable,
    output logic        shot,
    output logic [8:0]  cursor_x,
    output logic [8:0]  cursor_y,
    output logic        coord_valid,
    output logic        trigger_held
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_CD_W = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ARMED    = 2'd1;
    localparam logic [1:0] c_HOLD     = 2'd2;
    localparam logic [1:0] c_COOLDOWN = 2'd3;

    logic [19:0]       r_sync1;
    logic [19:0]       r_sync2;
    logic              r_strobe_d;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_CD_W-1:0] r_cool_cnt;
    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              w_cool_load;
    logic              w_rise;
    logic              w_trig;
    logic [8:0]        w_x;
    logic [8:0]        w_y;
    logic              w_unused;

    assign w_x      = r_sync2[8:0];
    assign w_y      = r_sync2[17:9];
    assign w_rise   = r_sync2[18] & ~r_strobe_d;
    assign w_trig   = ~r_sync2[19];
    assign w_unused = ^GPIO[35:20];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_strobe_d  <= 1'b0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            coord_valid <= 1'b0;
        end else begin
            r_sync1    <= GPIO[19:0];
            r_sync2    <= r_sync1;
            r_strobe_d <= r_sync2[18];
            if (w_rise) begin
                cursor_x    <= (w_x > 9'd319) ? 9'd319 : w_x;
                cursor_y    <= (w_y > 9'd239) ? 9'd239 : w_y;
                coord_valid <= 1'b1;
            end
        end
    end

    // Accept a new trigger level only after it differs for DEBOUNCE_CYCLES in a row
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_db_cnt     <= '0;
            trigger_held <= 1'b0;
        end else if (w_trig == trigger_held) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt     <= '0;
            trigger_held <= w_trig;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_IDLE;
            r_cool_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_cool_load)
                r_cool_cnt <= c_CD_W'(COOLDOWN_CYCLES);
            else if (r_cool_cnt != '0)
                r_cool_cnt <= r_cool_cnt - 1'b1;
        end
    end

    // ARMED is only entered with the trigger released, so a held level there is a fresh press
    always_comb begin
        w_next      = r_state;
        shot        = 1'b0;
        w_cool_load = 1'b0;
        if (!fire_enable) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!trigger_held)
                        w_next = c_ARMED;
                end
                c_ARMED: begin
                    if (trigger_held) begin
                        w_next = c_HOLD;
                        shot   = 1'b1;
                    end
                end
                c_HOLD: begin
                    if (!trigger_held) begin
                        w_next      = c_COOLDOWN;
                        w_cool_load = 1'b1;
                    end
                end
                c_COOLDOWN: begin
                    if (r_cool_cnt == '0)
                        w_next = trigger_held ? c_HOLD : c_ARMED;
                end
                default: w_next = c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gun_sampler.sv
// ============================================================================
// Module      : tb_gun_sampler
// Description : Scoreboard bench for gun_sampler (DEBOUNCE_CYCLES=4,
//               COOLDOWN_CYCLES=10); expected events are timestamped in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gun_sampler;

    typedef struct {
        int c;
        int v;
    } ev_t;

    logic        Clk;
    logic        Reset;
    logic [35:0] GPIO;
    logic        fire_enable;
    logic        shot;
    logic [8:0]  cursor_x;
    logic [8:0]  cursor_y;
    logic        coord_valid;
    logic        trigger_held;

    int  cyc;
    int  ntests;
    int  nfail;
    bit  mon_en;
    int  prev_cur;
    bit  prev_held;
    ev_t shot_q[$];
    ev_t held_q[$];
    ev_t cur_q[$];

    gun_sampler #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(10)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .GPIO        (GPIO),
        .fire_enable (fire_enable),
        .shot        (shot),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .coord_valid (coord_valid),
        .trigger_held(trigger_held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int pack_cur(input int v, input int x, input int y);
        return (v << 18) | (x << 9) | y;
    endfunction

    // Monitor: pops an expectation whenever the DUT presents an event
    always @(posedge Clk) begin
        #1;
        if (mon_en) begin
            int  cur;
            ev_t e;
            cur = pack_cur(int'(coord_valid), int'(cursor_x), int'(cursor_y));
            if (shot) begin
                if (shot_q.size() == 0) chk("shot_unexpected", cyc, -1);
                else begin
                    e = shot_q.pop_front();
                    chk("shot_cycle", cyc, e.c);
                end
            end
            if (trigger_held != prev_held) begin
                if (held_q.size() == 0) chk("held_unexpected", cyc, -1);
                else begin
                    e = held_q.pop_front();
                    chk("held_cycle", cyc, e.c);
                    chk("held_value", int'(trigger_held), e.v);
                end
            end
            if (cur != prev_cur) begin
                if (cur_q.size() == 0) chk("cursor_unexpected", cur, -1);
                else begin
                    e = cur_q.pop_front();
                    chk("cursor_cycle", cyc, e.c);
                    chk("cursor_value", cur, e.v);
                end
            end
            prev_held = trigger_held;
            prev_cur  = cur;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic strobe(input int x, input int y, input int ex, input int ey);
        @(negedge Clk);
        GPIO[8:0]  = x[8:0];
        GPIO[17:9] = y[8:0];
        GPIO[18]   = 1'b1;
        cur_q.push_back(ev_t'{cyc + 3, pack_cur(1, ex, ey)});
        @(negedge Clk);
        GPIO[18] = 1'b0;
        wait_cyc(6);
    endtask

    task automatic trig(input bit pressed, input bit exp_change, input bit exp_shot);
        @(negedge Clk);
        GPIO[19] = ~pressed;
        if (exp_change) held_q.push_back(ev_t'{cyc + 6, int'(pressed)});
        if (exp_shot) shot_q.push_back(ev_t'{cyc + 6, 1});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_shot"}, int'(shot), 0);
        chk({tag, "_x"}, int'(cursor_x), 0);
        chk({tag, "_y"}, int'(cursor_y), 0);
        chk({tag, "_valid"}, int'(coord_valid), 0);
        chk({tag, "_held"}, int'(trigger_held), 0);
    endtask

    initial begin
        int k;
        ntests      = 0;
        nfail       = 0;
        mon_en      = 1'b0;
        Reset       = 1'b1;
        fire_enable = 1'b0;
        GPIO        = 36'h0;
        GPIO[35:20] = 16'hA5C3;
        GPIO[19]    = 1'b1;
        wait_cyc(3);
        check_zero("reset");
        Reset = 1'b0;
        prev_held = trigger_held;
        prev_cur  = pack_cur(int'(coord_valid), int'(cursor_x), int'(cursor_y));
        mon_en    = 1'b1;
        wait_cyc(6);

        // Captures, including clamping boundaries
        strobe(100, 50, 100, 50);
        @(negedge Clk);
        GPIO[8:0]  = 9'd400;
        GPIO[17:9] = 9'd300;
        GPIO[18]   = 1'b1;
        cur_q.push_back(ev_t'{cyc + 3, pack_cur(1, 319, 239)});
        wait_cyc(8);
        GPIO[8:0]  = 9'd5;
        GPIO[17:9] = 9'd5;
        wait_cyc(12);
        GPIO[18] = 1'b0;
        wait_cyc(6);
        strobe(319, 0, 319, 0);
        strobe(320, 240, 319, 239);
        strobe(12, 7, 12, 7);

        // Glitch, then a real press
        fire_enable = 1'b1;
        wait_cyc(3);
        trig(1, 0, 0);
        wait_cyc(2);
        trig(0, 0, 0);
        wait_cyc(10);
        trig(1, 1, 1);
        wait_cyc(12);
        trig(0, 1, 0);
        wait_cyc(7);

        // Re-press inside cooldown fires nothing; after expiry it fires
        trig(1, 1, 0);
        wait_cyc(11);
        trig(0, 1, 0);
        wait_cyc(24);
        trig(1, 1, 1);
        wait_cyc(11);
        trig(0, 1, 0);
        wait_cyc(24);

        // Trigger already held when fire_enable rises
        fire_enable = 1'b0;
        wait_cyc(2);
        trig(1, 1, 0);
        wait_cyc(12);
        fire_enable = 1'b1;
        wait_cyc(10);
        trig(0, 1, 0);
        wait_cyc(9);
        trig(1, 1, 1);
        wait_cyc(11);
        trig(0, 1, 0);
        wait_cyc(10);

        // Reset mid-debounce discards progress
        fire_enable = 1'b0;
        wait_cyc(2);
        trig(1, 0, 0);
        wait_cyc(3);
        k     = cyc;
        Reset = 1'b1;
        cur_q.push_back(ev_t'{k + 1, 0});
        held_q.push_back(ev_t'{k + 5, 1});
        @(negedge Clk);
        check_zero("midreset");
        Reset = 1'b0;
        wait_cyc(10);
        trig(0, 1, 0);
        wait_cyc(12);

        chk("shot_q_left", shot_q.size(), 0);
        chk("held_q_left", held_q.size(), 0);
        chk("cursor_q_left", cur_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
